// File: rtl/uart_rx_fifo.sv
// Purpose : 8N1 UART receiver (mid-bit sampling) feeding a show-ahead byte FIFO for the keyboard path.
// Latency : a byte is visible on DATA_OUT one cycle after its stop bit is sampled (~9.5 bit times + 3 clk).
// Backpr. : none on the serial side; a good byte arriving with the FIFO full is dropped and OVERRUN pulses.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET_N      asynchronous active-low reset
//   IN_SERIAL_RX asynchronous serial line, idle high
//   RD_EN        pop head byte (ignored when EMPTY)
//   DATA_OUT     head byte, valid while EMPTY=0 (reads 0 when empty)
//   EMPTY/FULL   FIFO status; COUNT = bytes held
//   FRAME_ERR    1-cycle pulse: stop bit low, byte dropped
//   OVERRUN      1-cycle pulse: good byte dropped because FIFO full
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               IN_SERIAL_RX,
  input  logic               RD_EN,
  output logic [7:0]         DATA_OUT,
  output logic               EMPTY,
  output logic               FULL,
  output logic [FIFO_AW:0]   COUNT,
  output logic               FRAME_ERR,
  output logic               OVERRUN
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0]      HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]      BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      CNT_DEC   = CW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer; reset to the idle (high) line level
  // ---------------------------------------------------------------------------
  logic rx_m;
  logic rx_s;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= IN_SERIAL_RX;
      rx_s <= rx_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t        state, state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push_req;
  logic          frame_err_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = (bit_cnt == '0) ? bit_cnt : bit_cnt - CNT_DEC;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    push_req    = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n   = S_START;
          bit_cnt_n = HALF_LOAD;
        end
      end
      S_START: begin
        // Re-check at mid start bit so a short low glitch is ignored.
        if (bit_cnt == '0) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            bit_cnt_n = BIT_LOAD;
            bit_idx_n = '0;
          end
        end
      end
      S_DATA: begin
        if (bit_cnt == '0) begin
          // LSB arrives first: shift right so bit 0 ends up in shreg[0].
          shreg_n   = {rx_s, shreg[7:1]};
          bit_cnt_n = BIT_LOAD;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_cnt == '0) begin
          if (rx_s) begin
            push_req = 1'b1;
            state_n  = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold here while the line stays low so a break reports only once.
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               pop;
  logic               push_ok;

  assign EMPTY    = (COUNT == '0);
  assign FULL     = (COUNT == CNT_FULL);
  assign DATA_OUT = EMPTY ? 8'h00 : mem[rd_ptr];

  assign pop     = RD_EN & ~EMPTY;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign push_ok = push_req & (~FULL | pop);

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      COUNT     <= '0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= frame_err_n;
      OVERRUN   <= push_req & ~push_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   COUNT <= COUNT + CNT_ONE;
        2'b01:   COUNT <= COUNT - CNT_ONE;
        default: COUNT <= COUNT;
      endcase
    end
  end

endmodule
